// File: rtl/seq_det_pkg.sv
// Shared constants and types for the serial pattern detectors.
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN   = 2;
  localparam int unsigned PAT_W_MAX   = 16;
  localparam logic [2:0]  DEF_PAT_101 = 3'b101;

  typedef enum logic {
    MATCH_RESTART = 1'b0,
    MATCH_OVERLAP = 1'b1
  } match_mode_e;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= W'(inc);
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with runtime pattern load,
// selectable overlap, registered match and saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W     = 3,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEF_PAT_101),
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned     FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  logic              hit;
  match_mode_e       mode;

  assign mode = match_mode_e'(overlap);

  // The compare window is the stored history plus the bit on the wire now,
  // which is what makes the match visible in the same cycle as its last bit.
  always_comb begin
    window = {hist, din};
    hit    = ~reset & en & ~pat_load & (fill == FILL_MAX) & (window == pat_r);
  end

  assign match = hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r <= RESET_PAT;
      hist  <= '0;
      fill  <= '0;
    end else if (pat_load) begin
      pat_r <= pat_in;
      hist  <= '0;
      fill  <= '0;
    end else if (en) begin
      if (hit && (mode == MATCH_RESTART)) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[PAT_W-2:0];
        if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (cnt_clr),
    .value (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: default instance plus a 2-bit counter instance.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic       cnt_clr = 1'b0;

  logic       match, match_q;
  logic [7:0] match_cnt;
  logic       match2, match_q2;
  logic [1:0] cnt2;

  int   checks = 0;
  int   errors = 0;
  logic sb_q[$];
  logic exp_m;
  logic sb_exp;
  int   exp_cnt8 = 0;
  int   exp_cnt2 = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match), .match_q(match_q), .match_cnt(match_cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match2), .match_q(match_q2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, push the expected match for the scoreboard and
  // advance the reference counters.
  task automatic apply(input logic e, input logic d, input logic o, input logic l,
                       input logic [2:0] p, input logic c, input logic em);
    en = e; din = d; overlap = o; pat_load = l; pat_in = p; cnt_clr = c;
    exp_m = em;
    sb_q.push_back(em);
    if (c) begin
      exp_cnt8 = em ? 1 : 0;
      exp_cnt2 = em ? 1 : 0;
    end else if (em) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  task automatic test_reset();
    en = 1'b1; din = 1'b1;
    #1;
    checks++; if (match !== 1'b0 || match2 !== 1'b0) begin errors++; $display("FAIL reset_match: got %b/%b expected 0", match, match2); end
    checks++; if (match_q !== 1'b0 || match_q2 !== 1'b0) begin errors++; $display("FAIL reset_match_q: got %b/%b expected 0", match_q, match_q2); end
    checks++; if (match_cnt !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0", match_cnt, cnt2); end
    @(posedge clk); #1;
    checks++; if (match !== 1'b0 || match_q !== 1'b0 || match_cnt !== 8'd0) begin errors++; $display("FAIL reset_held: got m=%b mq=%b cnt=%0d expected 0", match, match_q, match_cnt); end
    reset = 1'b0; en = 1'b0; din = 1'b0;
    exp_cnt8 = 0; exp_cnt2 = 0;
  endtask

  task automatic test_overlap();
    logic [4:0] dv = 5'b10101;
    logic [4:0] ev = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, dv[4-i], 1'b1, 1'b0, 3'b000, 1'b0, ev[4-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL overlap_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL overlap_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL overlap_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
    end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL overlap_total: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_no_overlap();
    logic [7:0] ld = 8'b10000000;
    logic [7:0] dv = 8'b01010101;
    logic [7:0] ev = 8'b00010001;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, dv[7-i], 1'b0, ld[7-i], 3'b101, ld[7-i], ev[7-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL nonovl_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL nonovl_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL nonovl_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
    end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL nonovl_total: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_en_gaps();
    logic [6:0] ld = 7'b1000000;
    logic [6:0] env = 7'b1100011;
    logic [6:0] dv = 7'b0111101;
    logic [6:0] ev = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      apply(env[6-i], dv[6-i], 1'b1, ld[6-i], 3'b101, ld[6-i], ev[6-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL en_gap_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL en_gap_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL en_gap_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
    end
  endtask

  task automatic test_pat_load();
    logic [5:0] ld = 6'b001000;
    logic [5:0] cl = 6'b100000;
    logic [5:0] dv = 6'b111110;
    logic [5:0] ev = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, dv[5-i], 1'b1, ld[5-i], 3'b110, cl[5-i], ev[5-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL load_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL load_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL load_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
    end
  endtask

  task automatic test_saturate();
    logic [16:0] ld  = 17'b1_0000000000000_000;
    logic [16:0] cl  = 17'b1_0000000000000_101;
    logic [16:0] env = 17'b1_1111111111111_011;
    logic [16:0] dv  = 17'b0_1010101010101_001;
    logic [16:0] ev  = 17'b0_0010101010101_001;
    for (int i = 0; i < 17; i++) begin
      apply(env[16-i], dv[16-i], 1'b1, ld[16-i], 3'b101, cl[16-i], ev[16-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL sat_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL sat_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
      if (i == 13) begin
        checks++; if (cnt2 !== 2'd3 || match_cnt !== 8'd6) begin errors++; $display("FAIL sat_peak: got %0d/%0d expected 3/6", cnt2, match_cnt); end
      end
      if (i == 14) begin
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr_alone: got %0d expected 0", cnt2); end
      end
    end
    checks++; if (cnt2 !== 2'd1 || match_cnt !== 8'd1) begin errors++; $display("FAIL sat_clr_with_match: got %0d/%0d expected 1/1", cnt2, match_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ld = 3'b100;
    logic [2:0] dv = 3'b001;
    logic [2:0] dv2 = 3'b101;
    logic [2:0] ev2 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, dv[2-i], 1'b1, ld[2-i], 3'b011, 1'b0, 1'b0);
      #1;
      checks++; if (match !== exp_m) begin errors++; $display("FAIL rmid_pre_match[%0d]: got %b expected %b", i, match, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp) begin errors++; $display("FAIL rmid_pre_match_q[%0d]: got %b expected %b", i, match_q, sb_exp); end
    end
    en = 1'b1; din = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (match !== 1'b0 || match_q !== 1'b0 || match_cnt !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL rmid_during: got m=%b mq=%b cnt=%0d/%0d expected all 0", match, match_q, match_cnt, cnt2); end
    @(posedge clk); #1;
    checks++; if (match !== 1'b0 || match_q !== 1'b0 || match_cnt !== 8'd0) begin errors++; $display("FAIL rmid_held: got m=%b mq=%b cnt=%0d expected all 0", match, match_q, match_cnt); end
    reset = 1'b0;
    exp_cnt8 = 0; exp_cnt2 = 0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, dv2[2-i], 1'b1, 1'b0, 3'b000, 1'b0, ev2[2-i]);
      #1;
      checks++; if (match !== exp_m || match2 !== exp_m) begin errors++; $display("FAIL rmid_match[%0d]: got %b/%b expected %b", i, match, match2, exp_m); end
      @(posedge clk); #1;
      sb_exp = sb_q.pop_front();
      checks++; if (match_q !== sb_exp || match_q2 !== sb_exp) begin errors++; $display("FAIL rmid_match_q[%0d]: got %b/%b expected %b", i, match_q, match_q2, sb_exp); end
      checks++; if (match_cnt !== 8'(exp_cnt8) || cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL rmid_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, match_cnt, cnt2, exp_cnt8, exp_cnt2); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_en_gaps();
    test_pat_load();
    test_saturate();
    test_reset_mid();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
